// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, ALU class encodings and the
// packed control bundle carried down the pipeline.
package mips_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned ALU_OP_W   = 3;
   localparam int unsigned FUNCT_W    = 6;

   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 3'b010;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ANDI  = 3'b011;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ORI   = 3'b100;
   localparam logic [ALU_OP_W-1:0] ALU_OP_XORI  = 3'b101;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SLTI  = 3'b110;

   typedef struct packed {
      logic                reg_write;
      logic                mem_to_reg;
      logic                mem_read;
      logic                mem_write;
      logic                branch;
      logic                alu_src;
      logic                reg_dst;
      logic [ALU_OP_W-1:0] alu_op;
   } ctrl_t;

   // Bubble bundle: nothing written, nothing accessed, ALU doing a harmless add.
   function automatic ctrl_t ctrl_bubble();
      ctrl_t c;
      c        = '0;
      c.alu_op = ALU_OP_ADD;
      return c;
   endfunction

endpackage

// File: rtl/id_ex_ctrl_reg.sv
// ID/EX control-bundle and valid flops: inserts bubbles on flush or an empty
// decode slot, holds on stall.
module id_ex_ctrl_reg
   import mips_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  stall,
   input  logic  flush,
   input  logic  id_valid,
   input  ctrl_t id_ctrl,
   output logic  ex_valid,
   output ctrl_t ex_ctrl
);

   logic bubble_c;

   // Flush wins over stall; an empty slot only becomes a bubble when not stalled.
   assign bubble_c = flush | (~stall & ~id_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
      end else if (bubble_c) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= ctrl_bubble();
      end else if (!stall) begin
         ex_valid <= 1'b1;
         ex_ctrl  <= id_ctrl;
      end
   end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the MIPS core. Optional bubble statistic counter
// is built only when ID_EX_PERF_EN is defined; otherwise the port reads zero.
module id_ex_reg #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ALU_OP_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [DATA_W-1:0]     id_pc_plus4,
   input  logic [DATA_W-1:0]     id_rs_data,
   input  logic [DATA_W-1:0]     id_rt_data,
   input  logic [DATA_W-1:0]     id_imm_ext,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [5:0]            id_funct,
   input  logic [ALU_OP_W-1:0]   id_alu_op,
   input  logic                  id_reg_write,
   input  logic                  id_mem_to_reg,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_branch,
   input  logic                  id_alu_src,
   input  logic                  id_reg_dst,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_pc_plus4,
   output logic [DATA_W-1:0]     ex_rs_data,
   output logic [DATA_W-1:0]     ex_rt_data,
   output logic [DATA_W-1:0]     ex_imm_ext,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [5:0]            ex_funct,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic                  ex_reg_write,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_branch,
   output logic                  ex_alu_src,
   output logic                  ex_reg_dst,
   output logic [31:0]           ex_bubble_count
);

   localparam int unsigned CTRL_OP_W = mips_pkg::ALU_OP_W;

   mips_pkg::ctrl_t id_ctrl;
   mips_pkg::ctrl_t ex_ctrl;
   logic            bubble_c;

   assign bubble_c = flush | (~stall & ~id_valid);

   always_comb begin
      id_ctrl            = '0;
      id_ctrl.reg_write  = id_reg_write;
      id_ctrl.mem_to_reg = id_mem_to_reg;
      id_ctrl.mem_read   = id_mem_read;
      id_ctrl.mem_write  = id_mem_write;
      id_ctrl.branch     = id_branch;
      id_ctrl.alu_src    = id_alu_src;
      id_ctrl.reg_dst    = id_reg_dst;
      id_ctrl.alu_op     = CTRL_OP_W'(id_alu_op);
   end

   id_ex_ctrl_reg u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .flush    (flush),
      .id_valid (id_valid),
      .id_ctrl  (id_ctrl),
      .ex_valid (ex_valid),
      .ex_ctrl  (ex_ctrl)
   );

   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_mem_read   = ex_ctrl.mem_read;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_branch     = ex_ctrl.branch;
   assign ex_alu_src    = ex_ctrl.alu_src;
   assign ex_reg_dst    = ex_ctrl.reg_dst;
   assign ex_alu_op     = ALU_OP_W'(ex_ctrl.alu_op);

   // Data and register-address fields, zeroed alongside the control bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_pc_plus4 <= '0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_imm_ext  <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_funct    <= '0;
      end else if (bubble_c) begin
         ex_pc_plus4 <= '0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_imm_ext  <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_funct    <= '0;
      end else if (!stall) begin
         ex_pc_plus4 <= id_pc_plus4;
         ex_rs_data  <= id_rs_data;
         ex_rt_data  <= id_rt_data;
         ex_imm_ext  <= id_imm_ext;
         ex_rs       <= id_rs;
         ex_rt       <= id_rt;
         ex_rd       <= id_rd;
         ex_funct    <= id_funct;
      end
   end

`ifdef ID_EX_PERF_EN
   // Saturating count of bubble-loading edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_bubble_count <= 32'd0;
      end else if (bubble_c && (ex_bubble_count != 32'hFFFF_FFFF)) begin
         ex_bubble_count <= ex_bubble_count + 32'd1;
      end
   end
`else
   assign ex_bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: driver pushes expected ex_* state per edge,
// monitor pops and compares after each edge or on an async-reset event.
module tb_id_ex_reg;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        alu_src;
      logic        reg_dst;
      logic [2:0]  alu_op;
      logic [5:0]  funct;
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] count;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid;
   logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [5:0]  id_funct;
   logic [2:0]  id_alu_op;
   logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
   logic        id_branch, id_alu_src, id_reg_dst;
   logic        ex_valid;
   logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [5:0]  ex_funct;
   logic [2:0]  ex_alu_op;
   logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
   logic        ex_branch, ex_alu_src, ex_reg_dst;
   logic [31:0] ex_bubble_count;

   int checks   = 0;
   int failures = 0;
   vec_t  exp_q[$];
   string nm_q[$];
   vec_t  model;
   event  chk_ev;

   always #5 clk = ~clk;

   id_ex_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_funct(id_funct), .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
      .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_branch(id_branch), .id_alu_src(id_alu_src),
      .id_reg_dst(id_reg_dst), .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
      .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
      .ex_reg_dst(ex_reg_dst), .ex_bubble_count(ex_bubble_count)
   );

   function automatic vec_t mk(input logic v, input logic [6:0] c, input logic [2:0] op,
                               input logic [5:0] fn, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd);
      vec_t r;
      r = '0;
      r.valid = v;
      {r.reg_write, r.mem_to_reg, r.mem_read, r.mem_write, r.branch, r.alu_src, r.reg_dst} = c;
      r.alu_op = op; r.funct = fn; r.pc = pc; r.rs_data = a; r.rt_data = b;
      r.imm = imm; r.rs = rs; r.rt = rt; r.rd = rd;
      return r;
   endfunction

   // Control bits ordered reg_write,mem_to_reg,mem_read,mem_write,branch,alu_src,reg_dst.
   vec_t v_add, v_lw, v_sw, v_beq, v_inv;
   initial begin
      v_add = mk(1'b1, 7'b1000001, 3'b010, 6'b100000, 32'h0000_0104, 32'h0000_0005,
                 32'h0000_0007, 32'h0000_1820, 5'd1, 5'd2, 5'd3);
      v_lw  = mk(1'b1, 7'b1110010, 3'b000, 6'b010000, 32'h0000_0108, 32'h0000_1000,
                 32'h0000_DEAD, 32'h0000_0010, 5'd4, 5'd5, 5'd0);
      v_sw  = mk(1'b1, 7'b0001010, 3'b000, 6'b001000, 32'h0000_010C, 32'h0000_1000,
                 32'h1234_5678, 32'h0000_0008, 5'd4, 5'd6, 5'd0);
      v_beq = mk(1'b1, 7'b0000100, 3'b001, 6'b000011, 32'h0000_0110, 32'h0000_0009,
                 32'h0000_0009, 32'h0000_0003, 5'd7, 5'd8, 5'd0);
      v_inv = v_add;
      v_inv.valid = 1'b0;
   end

   function automatic vec_t sample();
      vec_t r;
      r = '0;
      r.valid = ex_valid;
      {r.reg_write, r.mem_to_reg, r.mem_read, r.mem_write, r.branch, r.alu_src, r.reg_dst} =
         {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst};
      r.alu_op = ex_alu_op; r.funct = ex_funct; r.pc = ex_pc_plus4;
      r.rs_data = ex_rs_data; r.rt_data = ex_rt_data; r.imm = ex_imm_ext;
      r.rs = ex_rs; r.rt = ex_rt; r.rd = ex_rd; r.count = ex_bubble_count;
      return r;
   endfunction

   task automatic step(input logic s, input logic f, input vec_t v, input string nm);
      stall = s; flush = f; id_valid = v.valid;
      {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst} =
         {v.reg_write, v.mem_to_reg, v.mem_read, v.mem_write, v.branch, v.alu_src, v.reg_dst};
      id_alu_op = v.alu_op; id_funct = v.funct; id_pc_plus4 = v.pc;
      id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm_ext = v.imm;
      id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
      if (f || (!s && !v.valid)) begin
         model = {1'b0, 7'b0, 3'b000, 6'b0, 128'b0, 15'b0, model.count};
`ifdef ID_EX_PERF_EN
         if (model.count != 32'hFFFF_FFFF) model.count = model.count + 32'd1;
`endif
      end else if (!s) begin
         model = {v[$bits(vec_t)-1:32], model.count};
      end
      exp_q.push_back(model);
      nm_q.push_back(nm);
      @(negedge clk);
   endtask

   // Monitor: compare after each rising edge, or immediately on an async-reset event.
   initial begin
      vec_t  e, a;
      string nm;
      forever begin
         @(posedge clk or chk_ev);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            a  = sample();
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL %s: got %h expected %h", nm, a, e);
            end
            checks++;
            if (!a.valid && (a.reg_write | a.mem_write | a.mem_read | a.branch) !== 1'b0) begin
               failures++;
               $display("FAIL %s_invariant: ctrl %b%b%b%b with ex_valid=0, required 0000",
                        nm, a.reg_write, a.mem_write, a.mem_read, a.branch);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t, required done", $time);
      $fatal(1);
   end

   initial begin
      model = '0;
      rst = 1'b1;
      step_idle();
      @(negedge clk);
      exp_q.push_back('0); nm_q.push_back("reset_state"); -> chk_ev;
      @(negedge clk);
      rst = 1'b0;

      step(1'b0, 1'b0, v_add, "load_add");
      step(1'b1, 1'b0, v_lw,  "stall_hold_1");
      step(1'b1, 1'b0, v_lw,  "stall_hold_2");
      step(1'b1, 1'b0, v_lw,  "stall_hold_3");
      step(1'b0, 1'b0, v_lw,  "lw_after_stall");
      step(1'b0, 1'b0, v_sw,  "load_sw");
      step(1'b1, 1'b1, v_beq, "flush_over_stall");
      step(1'b0, 1'b0, v_add, "reload_add");
      step(1'b0, 1'b0, v_inv, "invalid_slot");
      step(1'b0, 1'b1, v_beq, "flush");
      step(1'b0, 1'b0, v_beq, "load_beq");
      step(1'b1, 1'b1, v_sw,  "flush_during_stall");
      step(1'b1, 1'b0, v_inv, "stall_on_bubble");
      step(1'b0, 1'b0, v_lw,  "load_lw2");

      // Async reset while stalled with ex_reg_write=1.
      stall = 1'b1;
      #2;
      rst = 1'b1;
      model = '0;
      exp_q.push_back('0); nm_q.push_back("async_reset"); -> chk_ev;
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, v_add, "load_after_reset");
      step(1'b0, 1'b1, v_add, "flush_after_reset");

`ifdef ID_EX_PERF_EN
      force dut.ex_bubble_count = 32'hFFFF_FFFF;
      #1;
      release dut.ex_bubble_count;
      model.count = 32'hFFFF_FFFF;
      step(1'b0, 1'b1, v_add, "saturate_flush");
      step(1'b0, 1'b0, v_inv, "saturate_invalid");
`endif

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic step_idle();
      stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
      id_pc_plus4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm_ext = '0;
      id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0; id_alu_op = '0;
      {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst} = '0;
   endtask

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
ID/EX pipeline register of the pipelined MIPS core. It captures decoded control, operands and register addresses from the decode stage and presents them to the execute stage. ex_alu_op and ex_funct feed alu_control directly. The block supports hazard-unit stall (hold), branch/jump flush (bubble) and upstream invalid slots, so execute never acts on a squashed instruction.

Parameters:
DATA_W, 32, operand/immediate/PC width
REG_ADDR_W, 5, register specifier width
ALU_OP_W, 3, alu_op width (matches alu_control input)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  hold current contents (from hazard unit)
flush  in  1  replace next contents with bubble
id_valid  in  1  decode slot holds a real instruction
id_pc_plus4  in  DATA_W  PC+4 of decoded instruction
id_rs_data  in  DATA_W  register file read port A
id_rt_data  in  DATA_W  register file read port B
id_imm_ext  in  DATA_W  sign/zero-extended immediate
id_rs, id_rt, id_rd  in  REG_ADDR_W each  register specifiers
id_funct  in  6  instr[5:0]
id_alu_op  in  ALU_OP_W  main-control ALU class
id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  in  1 each  control bits
ex_valid  out  1  execute slot valid
ex_* (one per id_* above)  out  same widths  registered copies
ex_bubble_count  out  32  bubble statistic (see Optional Feature)

Behaviour:
- All state updates on rising clk; rst asynchronous, active-high, overrides everything.
- Reset: every output 0 (ex_valid=0, ex_alu_op=3'b000, all control 0, data/addresses 0, ex_bubble_count=0).
- Per-cycle priority: flush > stall > load.
- flush=1 (regardless of stall): load bubble: ex_valid=0, all control bits 0, ex_alu_op=3'b000 (ADD, harmless), ex_funct=0, data/address fields 0.
- stall=1, flush=0: all outputs hold unchanged, including ex_valid.
- Load (stall=0, flush=0): id_valid=1 copies all id_* fields. id_valid=0 loads bubble exactly as flush.
- Invariant: ex_valid=0 implies ex_reg_write=ex_mem_write=ex_mem_read=ex_branch=0 on the same cycle.
- Latency: exactly 1 cycle from id_* to ex_*. No combinational path from inputs to outputs.
- Stall held for N cycles: outputs constant for N cycles, then the next un-stalled edge loads the current id_*.
- rst asserted mid-stall or mid-flush: outputs go to reset values immediately (async). First edge after deassert performs a normal load.

Optional Feature:
ID_EX_PERF_EN defined: ex_bubble_count increments by 1 on every edge that loads a bubble (flush=1, or stall=0 with id_valid=0). Saturates at 32'hFFFF_FFFF and never wraps. Held during stall without flush. Cleared only by rst.
Undefined: ex_bubble_count is tied to 32'd0 and no counter flops are built. The port is always present so the top-level wiring does not change.

Decomposition:
- Shared package mips_pkg: DATA_W/REG_ADDR_W/ALU_OP_W constants; ALU_OP_ADD=3'b000, ALU_OP_SUB=3'b001, ALU_OP_RTYPE=3'b010, ALU_OP_ANDI=3'b011, ALU_OP_ORI=3'b100, ALU_OP_XORI=3'b101, ALU_OP_SLTI=3'b110; packed control-bundle typedef (7 control bits + alu_op).
- Sub-module id_ex_ctrl_reg: control-bundle + valid flops with bubble insertion and stall hold. The top instantiates it and holds the data/address flops.

Test Plan:
- Reset: rst=1 mid-run with ex_reg_write=1 -> all outputs 0 asynchronously, before the next clk edge.
- Load: id_valid=1, R-type add (id_alu_op=3'b010, id_funct=6'b100000, id_rs_data=32'h0000_0005, id_reg_write=1, id_reg_dst=1) -> next cycle ex_* equal inputs, ex_valid=1.
- Stall: stall=1 for 3 cycles while id_* changes to an lw (alu_op=000, mem_read=1) -> ex_* hold the add for 3 cycles; lw appears on the cycle after stall drops.
- Flush vs stall: flush=1 and stall=1 together with ex holding sw (mem_write=1) -> next cycle ex_valid=0, ex_mem_write=0, ex_alu_op=3'b000.
- Invalid slot: id_valid=0 with id_reg_write=1 -> next cycle ex_reg_write=0, ex_valid=0.
- ID_EX_PERF_EN: 2 flushes + 1 id_valid=0 load + 1 flush during stall -> ex_bubble_count=4. Force counter to 32'hFFFF_FFFF, then flush -> count stays 32'hFFFF_FFFF. With macro undefined -> count stays 0.
